scan_seq_ctrl: RTL and testbench

Sequencer and display-data controller for the 7-segment scan multiplexer. It divides the system clock to generate the 3-bit Scan index and inserts blanking gaps between digits to suppress ghosting. It also holds shadow copies of the Hexs/point/LES display data, which are refreshed only at frame boundaries through a req/ack handshake. Sits between the CPU debug/IO logic and the scan multiplexer.

---
 rtl/scan_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: digit-scan sequencer and frame-synchronous display shadow registers.
// Divides clk into per-digit dwell periods, inserts blanking gaps between digits,
// and loads new display data only at frame boundaries (or while idle).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   en           1 = scanning runs, 0 = idle and blanked
//   Hexs_in      new hex digit data (32)
//   point_in     new decimal-point data (8)
//   LES_in       new digit-enable data (8)
//   upd_req      update request, held until upd_ack
//   upd_ack      1-cycle pulse: *_in captured into shadows this cycle
//   Scan         digit index (3)
//   Hexs         shadow digit data (32)
//   point        shadow point data (8)
//   LES          shadow enable data (8)
//   blank        1 = downstream turns all digits off
//   frame_start  1-cycle pulse in the first cycle Scan reads 0 after a wrap
module scan_seq_ctrl #(
    parameter int unsigned DIV_W     = 17,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] Hexs_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LES_in,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [2:0]  Scan,
    output logic [31:0] Hexs,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic        blank,
    output logic        frame_start
);

    // Blank counter is at least 1 bit wide so BLANK_CYC of 0 or 1 still elaborates.
    localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] B_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISP,
        S_BLANK
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [2:0]        scan_q, scan_d;
    logic [31:0]       hexs_q, hexs_d;
    logic [7:0]        point_q, point_d;
    logic [7:0]        les_q, les_d;
    logic              req_q, req_d;
    logic              fs_q, fs_d;

    logic              tick;
    logic              adv;
    logic              wrap;
    logic              pending;
    logic              load;
    logic              ack;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bcnt_d  = bcnt_q;
        scan_d  = scan_q;
        adv     = 1'b0;
        tick    = (div_q == '1);

        unique case (state_q)
            S_IDLE: begin
                div_d  = '0;
                bcnt_d = '0;
                if (en) begin
                    state_d = S_DISP;
                end
            end
            S_DISP: begin
                div_d = div_q + DIV_W'(1);
                if (tick) begin
                    if (BLANK_CYC > 0) begin
                        state_d = S_BLANK;
                        div_d   = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (bcnt_q == B_LAST) begin
                    bcnt_d  = '0;
                    adv     = 1'b1;
                    state_d = S_DISP;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling overrides everything: park in IDLE with Scan frozen.
        if (!en) begin
            state_d = S_IDLE;
            div_d   = '0;
            bcnt_d  = '0;
            adv     = 1'b0;
        end

        if (adv) begin
            scan_d = scan_q + 3'd1;
        end
    end

    // Shadows load only when the 7->0 advance is taken or while idle,
    // so a displayed frame is never a mix of old and new data.
    always_comb begin
        wrap    = adv && (scan_q == 3'd7);
        pending = upd_req | req_q;
        load    = (state_q == S_IDLE) | wrap;
        ack     = rst_n & load & pending;
        req_d   = pending & ~ack;
        fs_d    = wrap;
        hexs_d  = ack ? Hexs_in  : hexs_q;
        point_d = ack ? point_in : point_q;
        les_d   = ack ? LES_in   : les_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bcnt_q  <= '0;
            scan_q  <= 3'd0;
            hexs_q  <= 32'd0;
            point_q <= 8'd0;
            les_q   <= 8'd0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            scan_q  <= scan_d;
            hexs_q  <= hexs_d;
            point_q <= point_d;
            les_q   <= les_d;
            req_q   <= req_d;
            fs_q    <= fs_d;
        end
    end

    assign upd_ack     = ack;
    assign Scan        = scan_q;
    assign Hexs        = hexs_q;
    assign point       = point_q;
    assign LES         = les_q;
    assign blank       = (state_q != S_DISP);
    assign frame_start = fs_q;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: scoreboard bench for scan_seq_ctrl.
// Instance A: DIV_W=3, BLANK_CYC=2. Instance B: DIV_W=2, BLANK_CYC=0.
module tb_scan_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, en_a, req_a;
    logic        rst_n_b, en_b, req_b;
    logic [31:0] hexs_in;
    logic [7:0]  point_in, les_in;

    logic        ack_a, blank_a, fs_a;
    logic [2:0]  scan_a;
    logic [31:0] hexs_a;
    logic [7:0]  point_a, les_a;

    logic        ack_b, blank_b, fs_b;
    logic [2:0]  scan_b;
    logic [31:0] hexs_b;
    logic [7:0]  point_b, les_b;

    scan_seq_ctrl #(.DIV_W(3), .BLANK_CYC(2)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .en          (en_a),
        .Hexs_in     (hexs_in),
        .point_in    (point_in),
        .LES_in      (les_in),
        .upd_req     (req_a),
        .upd_ack     (ack_a),
        .Scan        (scan_a),
        .Hexs        (hexs_a),
        .point       (point_a),
        .LES         (les_a),
        .blank       (blank_a),
        .frame_start (fs_a)
    );

    scan_seq_ctrl #(.DIV_W(2), .BLANK_CYC(0)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .en          (en_b),
        .Hexs_in     (hexs_in),
        .point_in    (point_in),
        .LES_in      (les_in),
        .upd_req     (req_b),
        .upd_ack     (ack_b),
        .Scan        (scan_b),
        .Hexs        (hexs_b),
        .point       (point_b),
        .LES         (les_b),
        .blank       (blank_b),
        .frame_start (fs_b)
    );

    typedef struct {
        logic [2:0]  scan;
        logic        blank;
        logic        fs;
        logic        ack;
        logic [31:0] hexs;
        logic [7:0]  point;
        logic [7:0]  les;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t mk(input int sc, input bit bl, input bit fs,
                                input bit ak, input logic [31:0] hx,
                                input logic [7:0] pt, input logic [7:0] le);
        exp_t e;
        e.scan  = 3'(sc);
        e.blank = bl;
        e.fs    = fs;
        e.ack   = ak;
        e.hexs  = hx;
        e.point = pt;
        e.les   = le;
        return e;
    endfunction

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_scan",  32'(scan_a),  32'(ea.scan));
            chk("a_blank", 32'(blank_a), 32'(ea.blank));
            chk("a_fs",    32'(fs_a),    32'(ea.fs));
            chk("a_ack",   32'(ack_a),   32'(ea.ack));
            chk("a_hexs",  hexs_a,       ea.hexs);
            chk("a_point", 32'(point_a), 32'(ea.point));
            chk("a_les",   32'(les_a),   32'(ea.les));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_scan",  32'(scan_b),  32'(eb.scan));
            chk("b_blank", 32'(blank_b), 32'(eb.blank));
            chk("b_fs",    32'(fs_b),    32'(eb.fs));
            chk("b_ack",   32'(ack_b),   32'(eb.ack));
            chk("b_hexs",  hexs_b,       eb.hexs);
            chk("b_point", 32'(point_b), 32'(eb.point));
            chk("b_les",   32'(les_b),   32'(eb.les));
        end
    end

    initial begin
        int          sc, u;
        bit          bl, fs, ak;
        logic [31:0] hx;
        logic [7:0]  pt, le;

        rst_n_a  = 1'b0;
        en_a     = 1'b0;
        req_a    = 1'b0;
        rst_n_b  = 1'b0;
        en_b     = 1'b0;
        req_b    = 1'b0;
        hexs_in  = 32'hDEAD_BEEF;
        point_in = 8'h11;
        les_in   = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        // Still in reset: reset values on both instances.
        qa.push_back(mk(0, 1, 0, 0, 32'h0, 8'h0, 8'h0));
        qb.push_back(mk(0, 1, 0, 0, 32'h0, 8'h0, 8'h0));

        // Release A with en=1: one IDLE cycle, then DISP.
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        en_a    = 1'b1;
        qa.push_back(mk(0, 1, 0, 0, 32'h0, 8'h0, 8'h0));

        for (int t = 0; t <= 180; t++) begin
            @(posedge clk); #1;
            en_a     = !(t >= 138 && t <= 145);
            req_a    = (t >= 32 && t <= 79) || (t == 141);
            hexs_in  = (t < 32) ? 32'hDEAD_BEEF : 32'h1234_ABCD;
            point_in = (t >= 100) ? 8'hA5 : 8'h11;

            if (t <= 138) begin
                sc = (t / 10) % 8;
                bl = (t % 10) >= 8;
                fs = (t > 0) && (t % 80 == 0);
            end else if (t <= 146) begin
                sc = 5;
                bl = 1'b1;
                fs = 1'b0;
            end else begin
                u  = t - 147;
                sc = (5 + u / 10) % 8;
                bl = (u % 10) >= 8;
                fs = (u == 30);
            end
            ak = (t == 79) || (t == 141);
            hx = (t >= 80) ? 32'h1234_ABCD : 32'h0;
            pt = (t < 80) ? 8'h00 : ((t < 142) ? 8'h11 : 8'hA5);
            le = (t >= 80) ? 8'h3C : 8'h00;
            qa.push_back(mk(sc, bl, fs, ak, hx, pt, le));
        end

        // Instance B: release with en=1, one IDLE cycle first.
        @(posedge clk); #1;
        rst_n_b = 1'b1;
        en_b    = 1'b1;
        qb.push_back(mk(0, 1, 0, 0, 32'h0, 8'h0, 8'h0));

        for (int s = 0; s <= 53; s++) begin
            @(posedge clk); #1;
            rst_n_b = !(s == 10 || s == 11);
            en_b    = 1'b1;
            req_b   = (s >= 5 && s <= 9);

            if (s <= 10) begin
                sc = (s / 4) % 8;
                bl = 1'b0;
                fs = 1'b0;
            end else if (s <= 12) begin
                sc = 0;
                bl = 1'b1;
                fs = 1'b0;
            end else begin
                u  = s - 13;
                sc = (u / 4) % 8;
                bl = 1'b0;
                fs = (u > 0) && (u % 32 == 0);
            end
            qb.push_back(mk(sc, bl, fs, 0, 32'h0, 8'h0, 8'h0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
